video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Generates raster timing for the pixel pipeline: signed beam coordinates, sync, data enable
//  and frame/line start strobes, all on video_clk_pix. Sits directly upstream of the test-pattern
//  frame generator and drives its sx/sy/hsync/vsync/video_enable/frame_start/line_start inputs.
//  Defaults are CEA 1280x720p60 at 74.25 MHz. Blanking is given negative coordinates;
//  the active area is sx in [0,H_RES-1] and sy in [0,V_RES-1].
// PARAMETERS
//  COORDSPC  16    coordinate width (bits, signed); must hold -(blank) .. RES-1
//  H_RES     1280  active pixels per line
//  H_FP      110   horizontal front porch (pixels)
//  H_SYNC    40    hsync width (pixels)
//  H_BP      220   horizontal back porch (pixels)
//  V_RES     720   active lines per frame
//  V_FP      5     vertical front porch (lines)
//  V_SYNC    5     vsync width (lines)
//  V_BP      20    vertical back porch (lines)
//  H_POL     1     hsync active level (1 = active-high)
//  V_POL     1     vsync active level
//  FCNT_W    16    frame counter width
// PORTS
//  video_clk_pix  in   1         pixel clock; the only clock
//  video_rst_n    in   1         asynchronous, active-low reset
//  sx             out  COORDSPC  signed horizontal position
//  sy             out  COORDSPC  signed vertical position
//  hsync          out  1         horizontal sync, level per H_POL
//  vsync          out  1         vertical sync, level per V_POL
//  video_enable   out  1         1 when sx>=0 and sy>=0 (active pixel)
//  line_start     out  1         1-cycle strobe at sx==H_STA
//  frame_start    out  1         1-cycle strobe at sx==H_STA and sy==V_STA
//  frame_count    out  FCNT_W    frames started since reset, wraps modulo 2^FCNT_W
// BEHAVIOUR
//  - H_STA = -(H_FP+H_SYNC+H_BP); V_STA = -(V_FP+V_SYNC+V_BP). Line order is front porch,
//    sync, back porch, active. The same order applies to the frame.
//  - sx counts H_STA..H_RES-1 and wraps to H_STA. sy advances by 1 only on the cycle sx wraps.
//    It counts V_STA..V_RES-1 and wraps to V_STA together with sx.
//  - hsync is active for sx in [H_STA+H_FP, H_STA+H_FP+H_SYNC-1].
//  - vsync is active for sy in [V_STA+V_FP, V_STA+V_FP+V_SYNC-1], for whole lines, at every sx.
//  - All outputs are registered and mutually aligned: in any cycle, hsync, vsync, video_enable,
//    the strobes and frame_count describe the sx/sy shown in that same cycle. This adds no
//    skew between outputs.
//  - Reset (video_rst_n=0, any time, async):
//    - sx=H_RES-1, sy=V_RES-1.
//    - hsync=~H_POL, vsync=~V_POL.
//    - video_enable=0, line_start=0, frame_start=0, frame_count=0.
//  - Reset mid-frame discards the frame. No partial-frame strobe is produced.
//  - Release of reset: the first rising edge moves to (H_STA,V_STA) with line_start=1,
//    frame_start=1 and frame_count=1. Frame 1 is therefore complete from its first pixel.
//  - frame_count increments on the same edge that raises frame_start, wrapping 2^FCNT_W-1 -> 0.
//  - Latency: none beyond the counter register. The downstream pattern stage registers colour
//    one cycle later, so the encoder stage must delay hsync/vsync/video_enable by 1 cycle.
//  - Counters never leave range. The comparisons are signed, so width truncation is forbidden:
//    elaboration must fail ($error) if H_STA or V_STA does not fit in COORDSPC.
//  - Period: (H_RES+H_FP+H_SYNC+H_BP) cycles per line; x (V_RES+V_FP+V_SYNC+V_BP) lines per frame.
// TESTING
//  1. Reset release, defaults -> first edge: sx=-370, sy=-30, frame_start=1, line_start=1,
//     frame_count=1, video_enable=0.
//  2. Line timing, defaults -> hsync=1 exactly for sx=-260..-221 (40 cycles).
//     line_start every 1650 cycles. video_enable=1 for 1280 cycles per active line.
//  3. Frame timing, defaults -> vsync=1 for sy=-25..-21 (5x1650 cycles).
//     frame_start every 1,237,500 cycles. Exactly 921,600 video_enable cycles per frame.
//  4. Polarity: H_POL=0, V_POL=0 -> hsync and vsync are inverted relative to test 2 and test 3.
//     Reset levels are 1.
//  5. Small raster: H_RES=4, H_FP=H_SYNC=H_BP=1, V_RES=2, V_FP=V_SYNC=V_BP=1, FCNT_W=2.
//     - sx sequence is -3,-2,-1,0,1,2,3,-3.
//     - sy increments on the wrap.
//     - frame_count goes 1,2,3,0 over 4 frames.
//  6. Async reset asserted at sx=100, sy=200 (defaults), held 3 cycles.
//     - Outputs go to reset values without waiting for a clock edge.
//     - After release, the sequence of test 1 repeats and frame_count=1.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: signed beam coordinates, sync, data enable,
// line/frame start strobes and a frame counter, all on the pixel clock.
module video_timing_gen #(
  parameter int COORDSPC = 16,
  parameter int H_RES    = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_RES    = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int FCNT_W   = 16
) (
  input  logic                       video_clk_pix,
  input  logic                       video_rst_n,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_enable,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [FCNT_W-1:0]          frame_count
);

  localparam int H_STA = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA = -(V_FP + V_SYNC + V_BP);
  localparam longint CMIN = -(64'sd1 <<< (COORDSPC - 1));
  localparam longint CMAX = (64'sd1 <<< (COORDSPC - 1)) - 1;

  // Signed compares below rely on every bound fitting the coordinate width.
  if (H_STA < CMIN || H_RES - 1 > CMAX) begin : g_hfit
    $error("H_STA or H_RES-1 does not fit in COORDSPC");
  end
  if (V_STA < CMIN || V_RES - 1 > CMAX) begin : g_vfit
    $error("V_STA or V_RES-1 does not fit in COORDSPC");
  end

  typedef logic signed [COORDSPC-1:0] coord_t;

  localparam coord_t HS   = coord_t'(H_STA);
  localparam coord_t HE   = coord_t'(H_RES - 1);
  localparam coord_t HSY0 = coord_t'(H_STA + H_FP);
  localparam coord_t HSY1 = coord_t'(H_STA + H_FP + H_SYNC - 1);
  localparam coord_t VS   = coord_t'(V_STA);
  localparam coord_t VE   = coord_t'(V_RES - 1);
  localparam coord_t VSY0 = coord_t'(V_STA + V_FP);
  localparam coord_t VSY1 = coord_t'(V_STA + V_FP + V_SYNC - 1);
  localparam logic   HACT = 1'(H_POL);
  localparam logic   VACT = 1'(V_POL);

  coord_t             sx_q, sx_d;
  coord_t             sy_q, sy_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic [FCNT_W-1:0]  fc_q, fc_d;
  logic               hwrap;

  // Every output is decoded from the next coordinates so all stay aligned.
  always_comb begin
    hwrap = (sx_q == HE);
    sx_d  = hwrap ? HS : sx_q + coord_t'(1);
    sy_d  = sy_q;
    if (hwrap) begin
      sy_d = (sy_q == VE) ? VS : sy_q + coord_t'(1);
    end
    hs_d = (sx_d >= HSY0 && sx_d <= HSY1) ? HACT : ~HACT;
    vs_d = (sy_d >= VSY0 && sy_d <= VSY1) ? VACT : ~VACT;
    de_d = ~sx_d[COORDSPC-1] & ~sy_d[COORDSPC-1];
    ls_d = (sx_d == HS);
    fs_d = ls_d && (sy_d == VS);
    fc_d = fs_d ? fc_q + FCNT_W'(1) : fc_q;
  end

  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      sx_q <= HE;
      sy_q <= VE;
      hs_q <= ~HACT;
      vs_q <= ~VACT;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      fc_q <= fc_d;
    end
  end

  assign sx           = sx_q;
  assign sy           = sy_q;
  assign hsync        = hs_q;
  assign vsync        = vs_q;
  assign video_enable = de_q;
  assign line_start   = ls_q;
  assign frame_start  = fs_q;
  assign frame_count  = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 720p raster, inverted polarity,
// and a tiny raster for wrap and frame counter behaviour.
`timescale 1ns/1ps
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_s = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] d_sx, d_sy, p_sx, p_sy, s_sx, s_sy;
  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic p_hs, p_vs, p_de, p_ls, p_fs;
  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [15:0] d_fc, p_fc;
  logic [1:0]  s_fc;

  video_timing_gen d (
    .video_clk_pix(clk), .video_rst_n(rst_n),
    .sx(d_sx), .sy(d_sy), .hsync(d_hs), .vsync(d_vs),
    .video_enable(d_de), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  video_timing_gen #(.H_POL(0), .V_POL(0)) p (
    .video_clk_pix(clk), .video_rst_n(rst_n),
    .sx(p_sx), .sy(p_sy), .hsync(p_hs), .vsync(p_vs),
    .video_enable(p_de), .line_start(p_ls),
    .frame_start(p_fs), .frame_count(p_fc)
  );

  video_timing_gen #(
    .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FCNT_W(2)
  ) s (
    .video_clk_pix(clk), .video_rst_n(rst_s),
    .sx(s_sx), .sy(s_sy), .hsync(s_hs), .vsync(s_vs),
    .video_enable(s_de), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  int ntot = 0;
  int npass = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_first(input string pfx);
    chk({pfx, "_sx"}, d_sx, -370);
    chk({pfx, "_sy"}, d_sy, -30);
    chk({pfx, "_fs"}, d_fs, 1);
    chk({pfx, "_ls"}, d_ls, 1);
    chk({pfx, "_fc"}, d_fc, 1);
    chk({pfx, "_de"}, d_de, 0);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_sx"}, d_sx, 1279);
    chk({pfx, "_sy"}, d_sy, 719);
    chk({pfx, "_hs"}, d_hs, 0);
    chk({pfx, "_vs"}, d_vs, 0);
    chk({pfx, "_de"}, d_de, 0);
    chk({pfx, "_ls"}, d_ls, 0);
    chk({pfx, "_fs"}, d_fs, 0);
    chk({pfx, "_fc"}, d_fc, 0);
    chk({pfx, "_phs"}, p_hs, 1);
    chk({pfx, "_pvs"}, p_vs, 1);
  endtask

  initial begin
    int mx, my, cyc, errs, perr;
    int hcnt, vcnt, decnt, lscnt, lastls, lsper;
    logic eh, ev, ede, els, efs;
    int sxexp [8];
    sxexp = '{-3, -2, -1, 0, 1, 2, 3, -3};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_first("first");

    mx = -370; my = -30; cyc = 0;
    errs = 0; perr = 0; hcnt = 0; vcnt = 0;
    decnt = 0; lscnt = 0; lastls = -1; lsper = 0;
    while (!(mx == 100 && my == 1)) begin
      eh  = (mx >= -260 && mx <= -221);
      ev  = (my >= -25 && my <= -21);
      ede = (mx >= 0 && my >= 0);
      els = (mx == -370);
      efs = els && (my == -30);
      if (d_sx !== 16'(mx) || d_sy !== 16'(my)) errs++;
      if (d_hs !== eh || d_vs !== ev || d_de !== ede) errs++;
      if (d_ls !== els || d_fs !== efs || d_fc !== 16'd1) errs++;
      if (p_hs !== ~eh || p_vs !== ~ev) perr++;
      if (my == -30 && d_hs) hcnt++;
      if (d_vs) vcnt++;
      if (my == 0 && d_de) decnt++;
      if (d_ls) begin
        if (lastls >= 0 && cyc - lastls != 1650) lsper++;
        lastls = cyc;
        lscnt++;
      end
      if (mx == 1279) begin
        mx = -370;
        my = (my == 719) ? -30 : my + 1;
      end else begin
        mx++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("trace_err", errs, 0);
    chk("pol_err", perr, 0);
    chk("hsync_cnt", hcnt, 40);
    chk("vsync_cyc", vcnt, 5 * 1650);
    chk("de_line", decnt, 1280);
    chk("ls_cnt", lscnt, 32);
    chk("ls_period", lsper, 0);
    chk("pre_sx", d_sx, 100);
    chk("pre_sy", d_sy, 1);

    #1 rst_n = 1'b0;
    #1 chk_reset("async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_first("rerun");

    rst_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("s_sx%0d", i), s_sx, sxexp[i]);
      chk($sformatf("s_hs%0d", i), s_hs, (sxexp[i] == -2) ? 1 : 0);
      if (i == 0) begin
        chk("s_sy0", s_sy, -3);
        chk("s_fc0", s_fc, 1);
        chk("s_fs0", s_fs, 1);
      end
      if (i == 7) begin
        chk("s_sy7", s_sy, -2);
        chk("s_ls7", s_ls, 1);
        chk("s_fs7", s_fs, 0);
      end
    end
    repeat (28) @(negedge clk);
    for (int f = 2; f <= 4; f++) begin
      chk($sformatf("s_fsf%0d", f), s_fs, 1);
      chk($sformatf("s_fcf%0d", f), s_fc, f % 4);
      chk($sformatf("s_sxf%0d", f), s_sx, -3);
      chk($sformatf("s_syf%0d", f), s_sy, -3);
      repeat (35) @(negedge clk);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
